// File: rtl/conv2_sum_collector_if.sv
// Adder-chain-to-output-buffer link for the conv layer 2 sum collector.
// One-cycle path: no stall, since every sum_valid is accepted and every write is taken by the buffer.
interface conv2_sum_collector_if #(
  parameter int IN_W   = 18,
  parameter int OUT_W  = 16,
  parameter int ADDR_W = 7
);
  logic                     start;
  logic signed [IN_W-1:0]   sum_in;
  logic                     sum_valid;
  logic                     wr_en;
  logic [ADDR_W-1:0]        wr_addr;
  logic signed [OUT_W-1:0]  wr_data;
  logic                     busy;
  logic                     layer_done;
  logic                     overflow;

  modport master (
    output start, sum_in, sum_valid,
    input  wr_en, wr_addr, wr_data, busy, layer_done, overflow
  );

  modport slave (
    input  start, sum_in, sum_valid,
    output wr_en, wr_addr, wr_data, busy, layer_done, overflow
  );
endinterface

// File: rtl/conv2_sum_collector.sv
// Accumulates NUM_CH channel sums per pixel, scales/saturates to OUT_W, writes pixels in row-major order.
// Write issued 1 cycle after the completing valid; no backpressure, so a valid is accepted every cycle.
module conv2_sum_collector #(
  parameter int IN_W     = 18,
  parameter int OUT_W    = 16,
  parameter int NUM_CH   = 3,
  parameter int OUT_ROWS = 10,
  parameter int OUT_COLS = 10,
  parameter int ADDR_W   = 7,
  parameter int SHIFT    = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  conv2_sum_collector_if.slave  bus
);
  localparam int ACC_W = IN_W + 4;
  localparam int NPIX  = OUT_ROWS * OUT_COLS;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] COLLECT = 2'd1;
  localparam logic [1:0] DONE    = 2'd2;

  localparam logic signed [OUT_W-1:0] OUT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic signed [OUT_W-1:0] OUT_MIN = {1'b1, {(OUT_W-1){1'b0}}};
  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-OUT_W){1'b0}}, OUT_MAX};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-OUT_W){1'b1}}, OUT_MIN};

  localparam logic [3:0]        LAST_CH  = 4'(NUM_CH - 1);
  localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(NPIX - 1);

  logic [1:0]               state;
  logic signed [ACC_W-1:0]  acc;
  logic [3:0]               ch_cnt;
  logic [ADDR_W-1:0]        pix_cnt;

  logic signed [ACC_W-1:0]  pix;
  logic signed [ACC_W-1:0]  shr;
  logic                     sat_hi;
  logic                     sat_lo;
  logic signed [OUT_W-1:0]  sat_val;
  logic                     last_ch;

  always_comb begin
    pix     = acc + $signed({{(ACC_W-IN_W){bus.sum_in[IN_W-1]}}, bus.sum_in});
    shr     = pix >>> SHIFT;
    sat_hi  = shr > SAT_MAX;
    sat_lo  = shr < SAT_MIN;
    sat_val = shr[OUT_W-1:0];
    if (sat_hi) begin
      sat_val = OUT_MAX;
    end else if (sat_lo) begin
      sat_val = OUT_MIN;
    end
    last_ch = (ch_cnt == LAST_CH);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      acc          <= '0;
      ch_cnt       <= '0;
      pix_cnt      <= '0;
      bus.wr_en    <= 1'b0;
      bus.wr_addr  <= '0;
      bus.wr_data  <= '0;
      bus.overflow <= 1'b0;
    end else begin
      bus.wr_en <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            acc          <= '0;
            ch_cnt       <= '0;
            pix_cnt      <= '0;
            bus.overflow <= 1'b0;
            state        <= COLLECT;
          end
        end
        COLLECT: begin
          if (bus.sum_valid) begin
            if (last_ch) begin
              acc         <= '0;
              ch_cnt      <= '0;
              pix_cnt     <= pix_cnt + 1'b1;
              bus.wr_en   <= 1'b1;
              bus.wr_addr <= pix_cnt;
              bus.wr_data <= sat_val;
              if (sat_hi || sat_lo) begin
                bus.overflow <= 1'b1;
              end
              // Last write and DONE land on the same cycle so layer_done aligns with it.
              if (pix_cnt == LAST_PIX) begin
                state <= DONE;
              end
            end else begin
              acc    <= pix;
              ch_cnt <= ch_cnt + 1'b1;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy       = (state == COLLECT);
  assign bus.layer_done = (state == DONE);
endmodule

// File: tb/tb_conv2_sum_collector.sv
// Bench for conv2_sum_collector: table vectors, corner sequences and randomized layers vs. a reference model.
module tb_conv2_sum_collector;
  localparam int IN_W   = 18;
  localparam int OUT_W  = 16;
  localparam int ADDR_W = 7;
  localparam int NUM_CH = 3;
  localparam int NPIX   = 100;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  conv2_sum_collector_if #(.IN_W(IN_W), .OUT_W(OUT_W), .ADDR_W(ADDR_W)) bus ();
  conv2_sum_collector_if #(.IN_W(IN_W), .OUT_W(OUT_W), .ADDR_W(ADDR_W)) bus2 ();

  assign bus2.start     = bus.start;
  assign bus2.sum_in    = bus.sum_in;
  assign bus2.sum_valid = bus.sum_valid;

  conv2_sum_collector #(.IN_W(IN_W), .OUT_W(OUT_W), .NUM_CH(NUM_CH), .OUT_ROWS(10), .OUT_COLS(10),
                        .ADDR_W(ADDR_W), .SHIFT(0)) dut0 (.clk(clk), .reset(reset), .bus(bus));
  conv2_sum_collector #(.IN_W(IN_W), .OUT_W(OUT_W), .NUM_CH(NUM_CH), .OUT_ROWS(10), .OUT_COLS(10),
                        .ADDR_W(ADDR_W), .SHIFT(2)) dut2 (.clk(clk), .reset(reset), .bus(bus2));

  int vectors = 0;
  int miscompares = 0;

  typedef struct { int addr; int data; } wr_t;
  wr_t q0[$];
  wr_t q2[$];
  int  done_cnt;
  int  done_last;

  always @(negedge clk) begin
    if (bus.wr_en)  q0.push_back('{int'(bus.wr_addr), int'(bus.wr_data)});
    if (bus2.wr_en) q2.push_back('{int'(bus2.wr_addr), int'(bus2.wr_data)});
    if (bus.layer_done) begin
      done_cnt++;
      if (bus.wr_en && bus.wr_addr == ADDR_W'(NPIX - 1)) done_last++;
    end
  end

  task automatic chk(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input bit v, input int s);
    bus.sum_valid = v;
    bus.sum_in    = IN_W'(s);
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    drive(1'b0, 0);
    bus.start = 1'b0;
    chk("busy_after_start", bus.busy, 1);
  endtask

  // Reference: whole-pixel sum, arithmetic shift, clamp to the signed output range.
  function automatic int sat_ref(input int total, input int sh, output bit ov);
    int r;
    r  = total >>> sh;
    ov = (r > 32767) || (r < -32768);
    if (r > 32767)  r = 32767;
    if (r < -32768) r = -32768;
    return r;
  endfunction

  function automatic int rand_sum();
    if ($urandom_range(0, 3) == 0) return int'($urandom_range(0, 262143)) - 131072;
    return int'($urandom_range(0, 16000)) - 8000;
  endfunction

  task automatic run_layer(input bit bubbles, input bit mid_start);
    int  exp0[$];
    int  exp2[$];
    bit  ov_layer;
    bit  ov;
    int  total;
    int  v;
    q0.delete();
    q2.delete();
    done_cnt  = 0;
    done_last = 0;
    ov_layer  = 1'b0;
    total     = 0;
    pulse_start();
    for (int i = 0; i < NPIX * NUM_CH; i++) begin
      if (bubbles) begin
        repeat ($urandom_range(0, 2)) drive(1'b0, int'($urandom));
      end
      v = rand_sum();
      total += v;
      if (i % NUM_CH == NUM_CH - 1) begin
        exp0.push_back(sat_ref(total, 0, ov));
        ov_layer |= ov;
        exp2.push_back(sat_ref(total, 2, ov));
        total = 0;
      end
      if (mid_start && i == 150) bus.start = 1'b1;
      drive(1'b1, v);
      bus.start = 1'b0;
    end
    chk("last_wr_en", bus.wr_en, 1);
    chk("layer_done_with_last", bus.layer_done, 1);
    chk("overflow_layer", bus.overflow, ov_layer);
    repeat (3) drive(1'b0, 0);
    chk("write_count", q0.size(), NPIX);
    chk("write_count_shift2", q2.size(), NPIX);
    for (int p = 0; p < NPIX; p++) begin
      if (p < q0.size()) begin
        chk("layer_addr", q0[p].addr, p);
        chk("layer_data", q0[p].data, exp0[p]);
      end
      if (p < q2.size()) chk("layer_data_shift2", q2[p].data, exp2[p]);
    end
    chk("layer_done_count", done_cnt, 1);
    chk("layer_done_on_addr99", done_last, 1);
    chk("busy_after_layer", bus.busy, 0);
  endtask

  typedef struct {
    int s0; int s1; int s2;
    int d0; int d2;
    bit ovf;
  } vec_t;
  vec_t tbl[6];

  initial begin
    tbl[0] = '{100, -30, 5, 75, 18, 1'b0};
    tbl[1] = '{1000, 2000, -500, 2500, 625, 1'b0};
    tbl[2] = '{400, 0, 0, 400, 100, 1'b0};
    tbl[3] = '{131071, 131071, 131071, 32767, 32767, 1'b1};
    tbl[4] = '{-131072, -131072, -131072, -32768, -32768, 1'b1};
    tbl[5] = '{-1, -1, -1, -3, -1, 1'b1};

    reset         = 1'b1;
    bus.start     = 1'b0;
    bus.sum_valid = 1'b0;
    bus.sum_in    = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_wr_en", bus.wr_en, 0);
    chk("reset_busy", bus.busy, 0);
    chk("reset_layer_done", bus.layer_done, 0);
    chk("reset_overflow", bus.overflow, 0);
    chk("reset_wr_addr", bus.wr_addr, 0);
    chk("reset_wr_data", bus.wr_data, 0);
    reset = 1'b0;

    drive(1'b1, 500);
    chk("valid_in_idle_ignored", bus.wr_en, 0);

    pulse_start();
    for (int k = 0; k < 6; k++) begin
      drive(1'b1, tbl[k].s0);
      drive(1'b1, tbl[k].s1);
      chk("no_early_write", bus.wr_en, 0);
      drive(1'b1, tbl[k].s2);
      chk("tbl_wr_en", bus.wr_en, 1);
      chk("tbl_wr_addr", bus.wr_addr, k);
      chk("tbl_wr_data", bus.wr_data, tbl[k].d0);
      chk("tbl_wr_data_shift2", bus2.wr_data, tbl[k].d2);
      chk("tbl_overflow", bus.overflow, tbl[k].ovf);
    end

    drive(1'b1, 7);
    drive(1'b0, -1);
    drive(1'b0, -1);
    drive(1'b1, 8);
    chk("bubble_no_write", bus.wr_en, 0);
    drive(1'b0, -1);
    drive(1'b0, -1);
    drive(1'b1, 9);
    chk("bubble_wr_en", bus.wr_en, 1);
    chk("bubble_wr_addr", bus.wr_addr, 6);
    chk("bubble_wr_data", bus.wr_data, 24);
    chk("bubble_wr_data_shift2", bus2.wr_data, 6);
    drive(1'b0, 0);
    chk("wr_en_single_cycle", bus.wr_en, 0);
    chk("wr_addr_holds", bus.wr_addr, 6);
    chk("wr_data_holds", bus.wr_data, 24);

    reset = 1'b1;
    drive(1'b0, 0);
    reset = 1'b0;
    pulse_start();
    q0.delete();
    drive(1'b1, 50);
    drive(1'b1, 60);
    reset = 1'b1;
    drive(1'b1, 70);
    reset = 1'b0;
    chk("reset_mid_no_write", bus.wr_en, 0);
    chk("reset_mid_busy", bus.busy, 0);
    repeat (3) drive(1'b0, 0);
    chk("reset_mid_no_queue_write", q0.size(), 0);
    pulse_start();
    drive(1'b1, 1);
    drive(1'b1, 2);
    drive(1'b1, 3);
    chk("after_reset_wr_en", bus.wr_en, 1);
    chk("after_reset_wr_addr", bus.wr_addr, 0);
    chk("after_reset_wr_data", bus.wr_data, 6);
    chk("after_reset_overflow", bus.overflow, 0);

    reset = 1'b1;
    drive(1'b0, 0);
    reset = 1'b0;
    run_layer(1'b0, 1'b1);
    run_layer(1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
